// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit SRAM accesses, low half first.
// Latency: 1 + 2*WAIT_CYCLES frozen cycles (IDLE, LO, HI), then one DONE cycle in which rd_data is valid.
// Backpressure: freeze stalls PC, IF/ID/EXE and MEM stage registers; it drops in DONE so the pipeline advances.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN       load / store request (store wins if both set)
//   ALU_Res, Val_Rm          byte address, store data
//   rd_data                  assembled load word, held until the next completed load
//   freeze                   pipeline stall request
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n   16-bit SRAM bus
//   mem_misalign             misaligned-request flag
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject requests with ALU_Res[1:0] != 0).

module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] rd_data,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        mem_misalign
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [16:0]   r_idx;
  logic [31:0]   r_data;
  logic          r_is_write;
  logic [15:0]   r_lo;
  logic [31:0]   r_rd_data;

  logic          w_req;
  logic          w_misalign;
  logic          w_start;
  logic          w_cnt_last;
  logic [16:0]   w_idx;

  assign w_req      = MEM_R_EN | MEM_W_EN;
  // Word index wraps modulo 2^17: upper address bits are simply dropped.
  assign w_idx      = 17'((ALU_Res - 32'(ADDR_BASE)) >> 2);
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_req & (ALU_Res[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = w_req & ~w_misalign;
  assign rd_data = r_rd_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and bus outputs; bus is decoded from registered state and latches only.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    sram_addr    = 18'd0;
    sram_dq_out  = 16'd0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;
    freeze       = 1'b0;
    mem_misalign = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_LO: begin
        sram_addr   = {r_idx, 1'b0};
        sram_dq_out = r_is_write ? r_data[15:0] : 16'd0;
        sram_dq_oe  = r_is_write;
        sram_we_n   = ~r_is_write;
        if (w_cnt_last) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HI: begin
        sram_addr   = {r_idx, 1'b1};
        sram_dq_out = r_is_write ? r_data[31:16] : 16'd0;
        sram_dq_oe  = r_is_write;
        sram_we_n   = ~r_is_write;
        if (w_cnt_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A rejected misaligned request must not stall the pipeline; reset forces the stall off.
    if (!rst) begin
      freeze       = w_req & (r_state != S_DONE) & ~((r_state == S_IDLE) & w_misalign);
      mem_misalign = w_misalign;
    end
  end

  // Request latches and load assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_data     <= '0;
      r_is_write <= 1'b0;
      r_lo       <= '0;
      r_rd_data  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_start) begin
        r_idx      <= w_idx;
        r_data     <= Val_Rm;
        r_is_write <= MEM_W_EN;
      end
      if ((r_state == S_LO) && w_cnt_last && !r_is_write) begin
        r_lo <= sram_dq_in;
      end
      if ((r_state == S_HI) && w_cnt_last && !r_is_write) begin
        r_rd_data <= {sram_dq_in, r_lo};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: vector table, hand-written corner sequences and random traffic
// checked against a word-level memory model with a halfword SRAM model on the bus.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_mem_stage_sram_ctrl;

  localparam int WC   = 2;
  localparam int BASE = 1024;
  localparam int NCYC = 2 * WC + 2;   // IDLE + LO*WC + HI*WC + DONE

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = 32'd0;
  logic [31:0] Val_Rm = 32'd0;
  logic [31:0] rd_data;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        mem_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .rd_data(rd_data), .freeze(freeze),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .mem_misalign(mem_misalign)
  );

  // Asynchronous halfword SRAM, zero-initialised
  bit [15:0] sram [0:262143];
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] = sram_dq_out;

  // Word-level reference memory keyed by word index
  logic [31:0] ref_mem [int];
  logic [31:0] cur_rd;

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return 17'((off / 4) % 131072);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] idx);
    if (ref_mem.exists(int'(idx))) return ref_mem[int'(idx)];
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drives one request and checks every cycle of its access. Leaves the request asserted
  // and returns 1 unit after the edge that ends DONE, so a following call is back-to-back.
  task automatic run_req(input logic w, input logic r, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd, input string tag);
    logic [16:0] idx;
    logic        is_lo, is_hi, exp_oe;
    MEM_W_EN = w;
    MEM_R_EN = r;
    ALU_Res  = addr;
    Val_Rm   = data;
    idx      = widx(addr);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      is_lo  = (c >= 1) && (c <= WC);
      is_hi  = (c > WC) && (c <= 2 * WC);
      exp_oe = w && (is_lo || is_hi);
      chk($sformatf("%s freeze c%0d", tag, c), 64'(freeze), 64'(c < NCYC - 1));
      chk($sformatf("%s oe/we_n c%0d", tag, c), {62'd0, sram_dq_oe, sram_we_n}, {62'd0, exp_oe, ~exp_oe});
      if (is_lo || is_hi)
        chk($sformatf("%s addr c%0d", tag, c), 64'(sram_addr), 64'({idx, is_hi}));
      if (exp_oe)
        chk($sformatf("%s dq_out c%0d", tag, c), 64'(sram_dq_out), 64'(is_hi ? data[31:16] : data[15:0]));
      if (c == 0)
        chk($sformatf("%s misalign", tag), 64'(mem_misalign), 64'd0);
      if (c == NCYC - 1)
        chk($sformatf("%s rd_data", tag), 64'(rd_data), 64'(exp_rd));
    end
    if (w) ref_mem[int'(idx)] = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle freeze %0d", i), 64'(freeze), 64'd0);
      chk($sformatf("idle bus %0d", i), {62'd0, sram_dq_oe, sram_we_n}, {62'd0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1028,   32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028,   32'h00000000, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1024,   32'hCAFEF00D, 32'h12345678};  // store wins, rd_data unchanged
    vecs[5] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd0,      32'hA5A55A5A, 32'hCAFEF00D};  // below base: index wraps
    vecs[7] = '{1'b0, 1'b1, 32'd0,      32'h00000000, 32'hA5A55A5A};
    vecs[8] = '{1'b0, 1'b1, 32'd525312, 32'h00000000, 32'hCAFEF00D};  // aliases word 0

    // Reset held two cycles with a pending load
    rst      = 1'b1;
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1024;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset freeze", 64'(freeze), 64'd0);
    chk("reset we_n", 64'(sram_we_n), 64'd1);
    chk("reset oe", 64'(sram_dq_oe), 64'd0);
    chk("reset rd_data", 64'(rd_data), 64'd0);
    chk("reset addr", 64'(sram_addr), 64'd0);
    chk("reset misalign", 64'(mem_misalign), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Vector table, applied back-to-back
    foreach (vecs[i])
      run_req(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, $sformatf("vec%0d", i));
    idle(2);

    // Back-to-back load then store: address sequence 2,3 then 4,5
    run_req(1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678, "b2b_ld");
    run_req(1'b1, 1'b0, 32'd1032, 32'h0BADC0DE, 32'h12345678, "b2b_st");
    idle(2);

    // Reset during the HI phase of a load
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1032;
    @(posedge clk);   // -> LO
    @(posedge clk);   // LO
    @(posedge clk);   // -> HI
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst freeze", 64'(freeze), 64'd0);
    chk("midrst rd_data held", 64'(rd_data), 64'h12345678);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    chk("midrst rd_data cleared", 64'(rd_data), 64'd0);
    chk("midrst bus released", {62'd0, sram_dq_oe, sram_we_n}, {62'd0, 1'b0, 1'b1});
    chk("midrst freeze after", 64'(freeze), 64'd0);
    @(posedge clk);
    #1;
    run_req(1'b0, 1'b1, 32'd1032, 32'd0, 32'h0BADC0DE, "after_rst_ld");
    cur_rd = 32'h0BADC0DE;

    // Random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      int unsigned op, k, lb;
      logic [31:0] a, d, e;
      op = $urandom_range(0, 2);
      k  = $urandom_range(0, 15);
`ifdef MEM_ALIGN_CHECK_EN
      lb = 0;
`else
      lb = $urandom_range(0, 3);
`endif
      a = 32'(BASE) + 32'(4 * k) + 32'(lb);
      d = $urandom;
      e = (op == 0) ? ref_rd(widx(a)) : cur_rd;
      run_req(op != 0, op != 1, a, d, e, $sformatf("rnd%0d", n));
      cur_rd = e;
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load is rejected: flag up, no stall, no bus activity
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1026;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("misalign flag %0d", i), 64'(mem_misalign), 64'd1);
      chk($sformatf("misalign freeze %0d", i), 64'(freeze), 64'd0);
      chk($sformatf("misalign bus %0d", i), {62'd0, sram_dq_oe, sram_we_n}, {62'd0, 1'b0, 1'b1});
      chk($sformatf("misalign rd_data %0d", i), 64'(rd_data), 64'(cur_rd));
      @(posedge clk);
      #1;
    end
    idle(1);
`else
    // Low address bits ignored: 1026 reads word 0
    run_req(1'b0, 1'b1, 32'd1026, 32'd0, ref_rd(17'd0), "unaligned_ld");
    idle(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage data-memory controller between the EXE stage register and the MEM stage register.
- Turns 32-bit load/store requests into two 16-bit external SRAM accesses (low half first, then high half).
- Asserts freeze to stall the upstream pipeline until the access completes.
- Delivers the assembled 32-bit load word to the MEM stage register as Mem_read_value_in.

Parameters:
ADDR_BASE, 1024, byte address mapped to SRAM word 0; subtracted from ALU_Res before indexing.
WAIT_CYCLES, 2, cycles each 16-bit phase is held on the SRAM bus (must be >=1).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
MEM_R_EN  input  1  load request from EXE stage register
MEM_W_EN  input  1  store request from EXE stage register
ALU_Res  input  32  byte address
Val_Rm  input  32  store data
rd_data  output  32  assembled load word; feeds Mem_read_value_in
freeze  output  1  stall request to PC, IF/ID/EXE stage registers and the MEM stage register
sram_addr  output  18  SRAM halfword address
sram_dq_out  output  16  write data to SRAM
sram_dq_oe  output  1  drive enable for the SRAM data bus
sram_dq_in  input  16  read data from SRAM
sram_we_n  output  1  SRAM write enable, active-low
mem_misalign  output  1  misaligned-access flag; see Optional Feature

Behaviour:
- Reset: all state is cleared on a clk edge with rst=1.
  - FSM goes to IDLE and the phase counter to 0.
  - rd_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, mem_misalign=0.
  - freeze is forced to 0 while rst=1.
- Reset mid-access aborts the access immediately. No partial rd_data update; the SRAM bus is released on the next cycle.
- Request: req = MEM_R_EN | MEM_W_EN. Write has priority if both are set; rd_data is then unchanged.
- Address: word index = (ALU_Res - ADDR_BASE)[18:2], 17 bits, modulo (upper bits ignored).
  - LO phase: sram_addr = {idx, 0}.
  - HI phase: sram_addr = {idx, 1}.
  - ALU_Res[1:0] is ignored unless MEM_ALIGN_CHECK_EN is defined.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on req, latch idx, Val_Rm and is_write; go to LO with cnt=0.
  - LO: cnt counts 0..WAIT_CYCLES-1. On the last cycle, capture sram_dq_in into lo_reg (reads), reset cnt, go to HI.
  - HI: same counting. On the last cycle, for reads, rd_data <= {sram_dq_in, lo_reg}. Go to DONE.
  - DONE: one cycle, then go to IDLE unconditionally.
- freeze = req & (state != DONE), combinational.
  - Freeze is high for 1 + 2*WAIT_CYCLES cycles per access (5 at default).
  - It is low in DONE, so the pipeline advances at the end of DONE.
  - A back-to-back request is seen in the following IDLE cycle and freezes again.
- No request: freeze=0, the FSM stays in IDLE, SRAM is idle (we_n=1, oe=0).
- Write bus behaviour:
  - sram_we_n=0 and sram_dq_oe=1 throughout LO and HI.
  - sram_dq_out = data[15:0] in LO and data[31:16] in HI.
  - Bus is released in DONE and IDLE.
- Read bus behaviour: sram_we_n=1 and sram_dq_oe=0 always.
- rd_data holds its value until the next completed read. Timing versus the MEM stage register: rd_data is valid during DONE and is captured at the end of DONE.
- SRAM outputs are decoded from the registered state/latches only, never directly from pipeline inputs.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a request with ALU_Res[1:0] != 0 does not start an access.
  - FSM stays in IDLE and freeze=0.
  - mem_misalign=1 for that cycle (combinational), and rd_data is unchanged.
- Undefined: mem_misalign is tied to 0 and the low address bits are ignored.

Test Plan:
- Reset: hold rst=1 for 2 cycles with MEM_R_EN=1 -> freeze=0, sram_we_n=1, sram_dq_oe=0, rd_data=0.
- Store: MEM_W_EN=1, ALU_Res=1024, Val_Rm=0xDEADBEEF ->
  - freeze high for 5 cycles;
  - addr 0 with dq_out 0xBEEF for 2 cycles, then addr 1 with 0xDEAD for 2 cycles, we_n=0 throughout;
  - freeze=0 on cycle 6.
- Load: model SRAM returns the stored halfwords; MEM_R_EN=1, ALU_Res=1024 -> rd_data=0xDEADBEEF in DONE, freeze low on cycle 6, dq_oe=0 throughout.
- Back-to-back: load at 1028 immediately followed by store at 1032 -> two 5-cycle freezes separated by one DONE cycle; sram_addr sequence 2, 3, 4, 5.
- Reset mid-access: assert rst during HI of a load -> next cycle state IDLE, rd_data=0, bus released; a new load afterwards completes normally.
- MEM_ALIGN_CHECK_EN: MEM_R_EN=1, ALU_Res=1026 -> mem_misalign=1, freeze=0, no SRAM activity.
